rfd_rot_step_gen: RTL
=====================

Name: rfd_rot_step_gen

Overview:
Rotation step generator: the transmit side of the 2-bit Gray-coded rotation interface whose receiver is the shift counter in the RFD core. It accepts a signed rotation-shift command and emits a paced sequence of single Gray steps on rot. A receiver that was reset or timed out before the command accumulates exactly the commanded shift and never flags a rotation error. The block sits in the RFD core between the phase-control logic and the rotation interface.

Parameters:
CTR_SIZE, 5, width of the signed shift command and remaining count; must be greater than 2.
STEP_DIV, 4, clock-enable cycles between consecutive rot steps; must be at least 1.
DIV_W, $clog2(STEP_DIV+1), width of the pacing counter (localparam, derived).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
en  in  1  clock enable; when low, all state holds
cmd_valid  in  1  shift command present
cmd_sh  in  CTR_SIZE  signed two's-complement requested shift
cmd_ready  out  1  block can accept a command
abort  in  1  cancel the command in progress
rot  out  2  Gray-coded rotation position
busy  out  1  command in progress
done  out  1  one-cycle pulse: commanded shift fully emitted
remaining  out  CTR_SIZE  signed steps still to emit

Behaviour:
- Reset (async, rst=1): rot=2'b00, cmd_ready=1, busy=0, done=0, remaining=0, pacing counter=0, state IDLE.
- All outputs are registered. Every update is qualified by en. With en=0, state, rot, counters and done all hold; a done pulse that is high stays high until the next enabled edge.
- Gray sequence, positive direction (+1 per step): 00 -> 10 -> 11 -> 01 -> 00. Negative direction (-1 per step): the reverse order, 00 -> 01 -> 11 -> 10 -> 00.
- rot changes by at most one Gray step per edge. Consecutive changes are exactly STEP_DIV enabled cycles apart.
- States: IDLE, STEP.
- IDLE: cmd_ready=1, busy=0.
  - Accept on an enabled edge with cmd_valid=1.
  - cmd_sh==0: done=1 on the next cycle, stay in IDLE, rot unchanged.
  - cmd_sh!=0: remaining<=cmd_sh, direction<=cmd_sh[CTR_SIZE-1], pacing counter<=0, go to STEP. From the next cycle cmd_ready=0 and busy=1.
- STEP: the pacing counter increments on each enabled cycle. When it reaches STEP_DIV-1:
  - rot advances one step in the latched direction;
  - remaining moves one toward zero (positive: -1, negative: +1);
  - the counter clears.
  - The first rot change appears STEP_DIV enabled cycles after the accept edge.
- Completion: on the edge where remaining goes to 0, the state goes to IDLE. In the following cycle done=1 (one enabled cycle), cmd_ready=1, busy=0, remaining=0.
- The most negative command, -2^(CTR_SIZE-1), is legal: it emits 2^(CTR_SIZE-1) negative steps and remaining counts up to 0 without overflow. The maximum positive command is 2^(CTR_SIZE-1)-1.
- cmd_valid while in STEP is ignored: no queueing and cmd_sh is not sampled.
- abort=1 on an enabled cycle in STEP:
  - state goes to IDLE, remaining<=0, pacing counter<=0, done not asserted;
  - rot holds its current value;
  - if the same edge would have produced a step, abort wins and no step occurs.
- abort in IDLE has no effect and does not block a simultaneous accept.
- rot is never reset by command completion. Position persists across commands; the next command starts from the current rot.
- Reset mid-command: immediate return to reset values, including rot=00.

Test Plan:
- Reset and hold: assert rst, toggle clk -> rot=00, cmd_ready=1, busy=0, done=0, remaining=0. Release rst with cmd_valid=0 for 10 cycles -> no change.
- Positive shift, STEP_DIV=1: cmd_sh=+3 -> rot 00,10,11,01 on 3 consecutive cycles, remaining 3,2,1,0, then done for 1 cycle, cmd_ready back to 1. A receiver model shows +3 and no rot_err.
- Negative shift and pacing, STEP_DIV=4: cmd_sh=-2 -> rot 00->01 four cycles after accept, then 01->11 four cycles later, remaining -2,-1,0, done pulse. A second command of +2 returns rot to 00.
- Edge commands, CTR_SIZE=5, STEP_DIV=1: cmd_sh=-16 -> 16 steps, rot ends at 00, receiver reads -16. cmd_sh=+15 -> 15 steps. cmd_sh=0 -> done one cycle after accept and rot unchanged.
- Abort and en: cmd_sh=+8, abort after 3 steps -> rot holds at 01, remaining=0, no done, cmd_ready=1 next cycle. Repeat with en=0 for 5 cycles mid-command -> the pacing count and rot freeze, then resume with the same spacing.
- Ignored command: cmd_valid with cmd_sh=-5 while busy -> no effect, and the original command completes unaltered.

Source files
------------

// File: rtl/rfd_rot_step_gen.sv
// ---------------------------------------------------------------------------
// rfd_rot_step_gen
//
// Transmit side of the 2-bit Gray-coded rotation interface. A signed shift
// command is accepted in IDLE and replayed as a paced train of single Gray
// steps on rot, one step every STEP_DIV enabled cycles, so a shift-counter
// receiver on the other end accumulates exactly the commanded shift.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-high
//   en         clock enable; all state holds while low
//   cmd_valid  shift command present (sampled only in IDLE)
//   cmd_sh     signed requested shift, CTR_SIZE bits
//   cmd_ready  high while a command can be accepted
//   abort      cancel the command in progress (no done pulse)
//   rot        Gray-coded rotation position, persists across commands
//   busy       command in progress
//   done       one enabled cycle pulse after the commanded shift completes
//   remaining  signed steps still to emit
// ---------------------------------------------------------------------------
module rfd_rot_step_gen #(
  parameter int CTR_SIZE = 5,
  parameter int STEP_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       cmd_valid,
  input  logic signed [CTR_SIZE-1:0] cmd_sh,
  output logic                       cmd_ready,
  input  logic                       abort,
  output logic [1:0]                 rot,
  output logic                       busy,
  output logic                       done,
  output logic signed [CTR_SIZE-1:0] remaining
);

  localparam int DIV_W = $clog2(STEP_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic signed [CTR_SIZE-1:0] REM_ONE = CTR_SIZE'(1);

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   rot_q, rot_d;
  logic signed [CTR_SIZE-1:0]   rem_q, rem_d;
  logic signed [CTR_SIZE-1:0]   rem_next;
  logic                         dir_q, dir_d;   // 1 = negative direction
  logic [DIV_W-1:0]             cnt_q, cnt_d;
  logic                         done_q, done_d;

  // One Gray step: positive 00->10->11->01->00, negative is the reverse.
  function automatic logic [1:0] gray_step(input logic [1:0] g, input logic neg);
    logic [1:0] r;
    if (!neg) begin
      case (g)
        2'b00:   r = 2'b10;
        2'b10:   r = 2'b11;
        2'b11:   r = 2'b01;
        default: r = 2'b00;
      endcase
    end else begin
      case (g)
        2'b00:   r = 2'b01;
        2'b01:   r = 2'b11;
        2'b11:   r = 2'b10;
        default: r = 2'b00;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    rot_d    = rot_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    // Moving toward zero from the most negative command never overflows,
    // since remaining only ever shrinks in magnitude.
    rem_next = dir_q ? (rem_q + REM_ONE) : (rem_q - REM_ONE);

    if (en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // abort is meaningless here and must not block an accept
          if (cmd_valid) begin
            if (cmd_sh == '0) begin
              done_d = 1'b1;
            end else begin
              rem_d   = cmd_sh;
              dir_d   = cmd_sh[CTR_SIZE-1];
              cnt_d   = '0;
              state_d = STEP;
            end
          end
        end
        STEP: begin
          if (abort) begin
            // abort takes priority over a step due on the same edge
            state_d = IDLE;
            rem_d   = '0;
            cnt_d   = '0;
          end else if (cnt_q == DIV_LAST) begin
            cnt_d = '0;
            rot_d = gray_step(rot_q, dir_q);
            rem_d = rem_next;
            if (rem_next == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rot_q   <= 2'b00;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign rot       = rot_q;
  assign remaining = rem_q;
  assign done      = done_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == STEP);

endmodule
